// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one W-bit XOR/AND/OR/XNOR unit among N valid/ready requesters.
// Results leave on a single valid/ready port tagged with the issuing requester's index.
module logic_op_arbiter #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int CNTW = 16,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [2*N-1:0]    req_op,
    input  logic [W*N-1:0]    req_a,
    input  logic [W*N-1:0]    req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_data,
    output logic [IDW-1:0]    res_id,
    output logic              busy,
    output logic [CNTW-1:0]   ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [IDW-1:0] win_id;
    logic           grant_any;
    logic [1:0]     sel_op, op_q;
    logic [W-1:0]   sel_a, sel_b, a_q, b_q, alu;
    logic [IDW-1:0] id_q;

    // Circular search starting at ptr; ptr+k never exceeds 2N-2, so one subtraction wraps it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_any = 1'b0;
        win_id    = '0;
        sel_op    = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                win_id    = IDW'(idx);
                sel_op    = req_op[2*idx +: 2];
                sel_a     = req_a[W*idx +: W];
                sel_b     = req_b[W*idx +: W];
            end
        end
    end

    assign ptr_nxt = (win_id == IDW'(N-1)) ? '0 : win_id + 1'b1;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++)
            req_ready[i] = (state == IDLE) && grant_any && (win_id == IDW'(i));
    end

    always_comb begin
        unique case (op_q)
            2'b00:   alu = a_q ^ b_q;
            2'b01:   alu = a_q & b_q;
            2'b10:   alu = a_q | b_q;
            default: alu = ~(a_q ^ b_q);
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_any) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            ops_done  <= '0;
        end else begin
            unique case (state)
                IDLE: if (grant_any) begin
                    op_q <= sel_op;
                    a_q  <= sel_a;
                    b_q  <= sel_b;
                    id_q <= win_id;
                    ptr  <= ptr_nxt;
                end
                EXEC: begin
                    res_data  <= alu;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    ops_done  <= ops_done + CNTW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter: expected results queued at grant, popped at result.
// A second instance (N=3, CNTW=4) covers pointer wrap on non-power-of-2 N and counter wrap.
module tb_logic_op_arbiter;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        res_valid, res_ready, busy;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic [15:0] ops_done;

    logic [2:0]  v3, r3;
    logic [5:0]  op3;
    logic [23:0] a3, b3;
    logic        rv3, rr3, busy3;
    logic [7:0]  rd3;
    logic [1:0]  ri3;
    logic [3:0]  od3;

    logic [1:0]  op_v [4];
    logic [7:0]  a_v  [4];
    logic [7:0]  b_v  [4];

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_ops = '0;
    time         last_grant;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_op[2*i +: 2] = op_v[i];
            req_a[8*i +: 8]  = a_v[i];
            req_b[8*i +: 8]  = b_v[i];
        end
    end

    logic_op_arbiter #(.N(4), .W(8), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy), .ops_done(ops_done)
    );

    logic_op_arbiter #(.N(3), .W(8), .CNTW(4)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(r3),
        .req_op(op3), .req_a(a3), .req_b(b3),
        .res_valid(rv3), .res_ready(rr3), .res_data(rd3),
        .res_id(ri3), .busy(busy3), .ops_done(od3)
    );

    function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a ^ b;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return ~(a ^ b);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_ops = '0;
        sb.delete();
    endtask

    // Entered at a negedge while the DUT is IDLE with req_valid already driven.
    task automatic run_op(input int id, input int hold, input bit keep);
        exp_t e;
        #1;
        check("grant", 32'(req_ready), 32'd1 << id);
        last_grant = $time;
        e.id   = 2'(id);
        e.data = model(op_v[id], a_v[id], b_v[id]);
        sb.push_back(e);
        @(negedge clk);
        if (!keep) req_valid[id] = 1'b0;
        res_ready = (hold == 0);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_res_valid", 32'(res_valid), 32'd0);
        check("exec_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("done_res_valid", 32'(res_valid), 32'd1);
        e = sb.pop_front();
        check("res_data", 32'(res_data), 32'(e.data));
        check("res_id", 32'(res_id), 32'(e.id));
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_res_data", 32'(res_data), 32'(e.data));
            check("hold_res_id", 32'(res_id), 32'(e.id));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_ops_done", 32'(ops_done), 32'(exp_ops));
            if (c == hold - 1) res_ready = 1'b1;
        end
        @(negedge clk);
        exp_ops = exp_ops + 16'd1;
        check("ops_done", 32'(ops_done), 32'(exp_ops));
        check("idle_res_valid", 32'(res_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        time prev;
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op_v[i] = '0;
            a_v[i]  = '0;
            b_v[i]  = '0;
        end
        v3  = '0;
        rr3 = 1'b1;
        op3 = {2'b11, 2'b10, 2'b01};
        a3  = {8'h3C, 8'h99, 8'hF0};
        b3  = {8'h0F, 8'h66, 8'h55};

        do_reset();
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_ops_done", 32'(ops_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);

        // Single XOR on requester 0.
        op_v[0] = 2'b00; a_v[0] = 8'hF0; b_v[0] = 8'h3C;
        req_valid = 4'b0001;
        run_op(0, 0, 1'b0);

        // Every opcode on requester 2.
        a_v[2] = 8'hA5; b_v[2] = 8'h0F;
        for (int op = 0; op < 4; op++) begin
            op_v[2] = 2'(op);
            req_valid = 4'b0100;
            run_op(2, 0, 1'b0);
        end

        // Round-robin with all four requesting continuously.
        do_reset();
        op_v[0] = 2'b01; a_v[0] = 8'hC3; b_v[0] = 8'h5A;
        op_v[1] = 2'b10; a_v[1] = 8'h12; b_v[1] = 8'h84;
        op_v[3] = 2'b11; a_v[3] = 8'h77; b_v[3] = 8'h70;
        req_valid = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            run_op(k % 4, 0, 1'b1);
            if (k > 0) check("rr_interval", 32'(last_grant - prev), 32'd30);
            prev = last_grant;
        end

        // Backpressure in DONE, then an immediate grant from the pointer onward.
        req_valid = 4'b1100;
        run_op(2, 5, 1'b0);
        run_op(3, 0, 1'b0);

        // Reset during EXEC discards the operation and restarts the pointer at 0.
        do_reset();
        req_valid = 4'b0010;
        #1;
        check("pre_rst_grant", 32'(req_ready), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ops_done", 32'(ops_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ops_done", 32'(ops_done), 32'd0);
        req_valid = 4'b1001;
        run_op(0, 0, 1'b0);

        // N=3 instance: grants cycle 0,1,2,0,... and the 4-bit counter wraps after 16.
        v3 = 3'b111;
        for (int k = 0; k < 17; k++) begin
            int j;
            j = k % 3;
            #1;
            check("n3_grant", 32'(r3), 32'd1 << j);
            @(negedge clk);
            @(negedge clk);
            check("n3_res_valid", 32'(rv3), 32'd1);
            check("n3_res_id", 32'(ri3), 32'(j));
            check("n3_res_data", 32'(rd3), 32'(model(op3[2*j +: 2], a3[8*j +: 8], b3[8*j +: 8])));
            @(negedge clk);
            check("n3_ops_done", 32'(od3), 32'((k + 1) % 16));
        end
        v3 = '0;
        check("n3_final_ops_done", 32'(od3), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
